// File: rtl/fetch.sv
// fetch: instruction fetch stage plus IF/ID pipeline register.
//
// Keeps the program counter and issues word reads to instruction memory,
// with at most one read outstanding. Delivers instructions to decode in
// program order and fills empty slots with NOP bubbles. Honours the decode
// stall and, on a redirect, restarts fetch at the new target and drops
// wrong-path responses.
//
// Ports:
//   clk_i, rst_n_i    clock, asynchronous active-low reset
//   stall_i           hold IF/ID, issue no new request
//   redirect_i        squash fetched work, restart at redirect_pc_i
//   redirect_pc_i     new fetch address (bits [1:0] ignored)
//   imem_req_o        single-cycle read strobe
//   imem_addr_o       read address (always equals the next fetch PC)
//   imem_valid_i      read data valid (1+ cycles after the request)
//   imem_rdata_i      read data
//   instr_o, pc_o     IF/ID instruction and its PC
module fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_inflight, pc_inflight_d;
  logic        hold_v, hold_v_d;
  logic [31:0] hold_instr, hold_instr_d;
  logic [31:0] hold_pc, hold_pc_d;
  logic [31:0] instr_d, pc_out_d;

  logic        outstanding;
  logic        resp;
  logic        issue;
  logic [31:0] redirect_aligned;

  // Word-align the redirect target by masking the byte-offset bits.
  assign redirect_aligned = redirect_pc_i & 32'hFFFF_FFFC;

  assign outstanding = (state == BUSY) || (state == DISCARD);
  // Only a kept (BUSY) response carries a usable instruction.
  assign resp        = (state == BUSY) && imem_valid_i;
  // A retiring response frees the single slot, so the next read can go
  // out in the same cycle.
  assign issue       = !redirect_i && !stall_i &&
                       ((state == IDLE) || (outstanding && imem_valid_i));

  // Gated by reset so the strobe is low while the block is held in reset.
  assign imem_req_o  = issue && rst_n_i;
  assign imem_addr_o = pc_q;

  // Next-state logic: FSM, PC, hold buffer and IF/ID register.
  always_comb begin
    state_d       = state;
    pc_d          = pc_q;
    pc_inflight_d = pc_inflight;
    hold_v_d      = hold_v;
    hold_instr_d  = hold_instr;
    hold_pc_d     = hold_pc;
    instr_d       = instr_o;
    pc_out_d      = pc_o;

    // FSM and PC; redirect has top priority.
    if (redirect_i) begin
      pc_d = redirect_aligned;
      if (outstanding && !imem_valid_i) begin
        state_d = DISCARD;
      end else begin
        state_d = IDLE;
      end
    end else if (issue) begin
      pc_d          = pc_q + 32'd4;
      pc_inflight_d = pc_q;
      state_d       = BUSY;
    end else if (outstanding && imem_valid_i) begin
      state_d = IDLE;
    end else begin
      state_d = state;
    end

    // Hold buffer: catches a response that arrives while decode is stalled.
    if (redirect_i) begin
      hold_v_d = 1'b0;
    end else if (stall_i) begin
      if (resp) begin
        hold_v_d     = 1'b1;
        hold_instr_d = imem_rdata_i;
        hold_pc_d    = pc_inflight;
      end else begin
        hold_v_d = hold_v;
      end
    end else if (hold_v) begin
      hold_v_d = 1'b0;
    end else begin
      hold_v_d = hold_v;
    end

    // IF/ID register.
    if (redirect_i) begin
      instr_d  = NOP_INSTR;
      pc_out_d = 32'h0000_0000;
    end else if (stall_i) begin
      instr_d  = instr_o;
      pc_out_d = pc_o;
    end else if (hold_v) begin
      instr_d  = hold_instr;
      pc_out_d = hold_pc;
    end else if (resp) begin
      instr_d  = imem_rdata_i;
      pc_out_d = pc_inflight;
    end else begin
      instr_d  = NOP_INSTR;
      pc_out_d = 32'h0000_0000;
    end
  end

  // State register for all fetch-stage storage.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      pc_q        <= RESET_PC;
      pc_inflight <= 32'h0000_0000;
      hold_v      <= 1'b0;
      hold_instr  <= 32'h0000_0000;
      hold_pc     <= 32'h0000_0000;
      instr_o     <= NOP_INSTR;
      pc_o        <= 32'h0000_0000;
    end else begin
      state       <= state_d;
      pc_q        <= pc_d;
      pc_inflight <= pc_inflight_d;
      hold_v      <= hold_v_d;
      hold_instr  <= hold_instr_d;
      hold_pc     <= hold_pc_d;
      instr_o     <= instr_d;
      pc_o        <= pc_out_d;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed testbench for the fetch stage. A small memory model
// returns word = address after a configurable latency.
module tb_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        req;
  logic [31:0] addr;
  logic        valid;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [31:0] pc;

  int checks = 0;
  int errors = 0;

  // memory model state
  int          lat = 1;
  bit          mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;
  logic        last_req;
  logic [31:0] last_addr;

  always #5 clk = ~clk;

  fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .imem_req_o   (req),
    .imem_addr_o  (addr),
    .imem_valid_i (valid),
    .imem_rdata_i (rdata),
    .instr_o      (instr),
    .pc_o         (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive memory response, sample request, clock, update model.
  task automatic step();
    if (mem_busy && mem_cnt == 1) begin
      valid = 1'b1;
      rdata = mem_addr;
    end else begin
      valid = 1'b0;
      rdata = 32'hDEAD_BEEF;
    end
    #1;
    last_req  = req;
    last_addr = addr;
    @(posedge clk);
    #1;
    if (valid) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (last_req) begin
      mem_busy = 1'b1;
      mem_cnt  = lat;
      mem_addr = last_addr;
    end
    stall    = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    valid       = 1'b0;
    rdata       = 32'h0;
    mem_busy    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, req}, 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    // streaming, 1-cycle memory
    lat = 1;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("str_req", {31'h0, last_req}, 32'h1);
      chk("str_addr", last_addr, 32'(4 * k));
      if (k >= 1) begin
        chk("str_instr", instr, 32'(4 * (k - 1)));
        chk("str_pc", pc, 32'(4 * (k - 1)));
      end
    end

    // stall while response for 8 arrives
    do_reset();
    step(); step(); step();
    chk("stl_pre", pc, 32'h4);
    for (int k = 0; k < 3; k++) begin
      stall = 1'b1;
      step();
      chk("stl_noreq", {31'h0, last_req}, 32'h0);
      chk("stl_instr", instr, 32'h4);
      chk("stl_pc", pc, 32'h4);
    end
    step();
    chk("stl_rel_addr", last_addr, 32'hC);
    chk("stl_rel_instr", instr, 32'h8);
    chk("stl_rel_pc", pc, 32'h8);
    step();
    chk("stl_next_pc", pc, 32'hC);
    step();
    chk("stl_next2_pc", pc, 32'h10);

    // redirect with a request outstanding, 3-cycle memory
    lat = 3;
    do_reset();
    for (int k = 0; k < 40 && !(last_req === 1'b1 && last_addr == 32'h10); k++) step();
    chk("rd_reach10", last_addr, 32'h10);
    chk("rd_pre_pc", pc, 32'hC);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    chk("rd_bub_instr", instr, 32'h0);
    chk("rd_bub_pc", pc, 32'h0);
    step();
    chk("rd_noreq", {31'h0, last_req}, 32'h0);
    step();
    chk("rd_tgt_req", {31'h0, last_req}, 32'h1);
    chk("rd_tgt_addr", last_addr, 32'h100);
    chk("rd_drop_pc", pc, 32'h0);
    chk("rd_drop_instr", instr, 32'h0);
    step();
    chk("rd_bub2_pc", pc, 32'h0);
    step();
    chk("rd_bub3_pc", pc, 32'h0);
    step();
    chk("rd_arr_pc", pc, 32'h100);
    chk("rd_arr_instr", instr, 32'h100);

    // redirect and stall together with hold buffer full
    lat = 1;
    do_reset();
    step(); step(); step();
    stall = 1'b1;
    step();
    chk("rs_hold_pc", pc, 32'h4);
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step();
    chk("rs_instr", instr, 32'h0);
    chk("rs_pc", pc, 32'h0);
    stall = 1'b1;
    step();
    chk("rs_stl_noreq", {31'h0, last_req}, 32'h0);
    step();
    chk("rs_tgt_addr", last_addr, 32'h200);
    chk("rs_nohold_pc", pc, 32'h0);
    step();
    chk("rs_arr_pc", pc, 32'h200);

    // wrap and alignment
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    step();
    chk("wr_addr0", last_addr, 32'hFFFF_FFFC);
    step();
    chk("wr_addr1", last_addr, 32'h0000_0000);
    chk("wr_pc", pc, 32'hFFFF_FFFC);

    // reset mid-flight, then a stale response after release
    do_reset();
    step(); step(); step();
    chk("rm_pre_pc", pc, 32'h4);
    rst_n = 1'b0;
    #1;
    chk("rm_instr", instr, 32'h0);
    chk("rm_pc", pc, 32'h0);
    chk("rm_req", {31'h0, req}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("rm_stale_was", {31'h0, valid}, 32'h1);
    chk("rm_first_addr", last_addr, 32'h0);
    chk("rm_ign_pc", pc, 32'h0);
    chk("rm_ign_instr", instr, 32'h0);
    step();
    step();
    chk("rm_next_pc", pc, 32'h4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
